// File: rtl/line_buff_sched.sv
// line_buff_sched: sequences the two VGA line buffers through a frame and schedules ping-pong refills.
// Define LBUFF_SCHED_UNDERRUN_CNT_EN to build the saturating underrun counter.
module line_buff_sched #(
    parameter int HEIGHT_PX        = 480,
    parameter int TILE_HEIGHT      = 4,
    parameter int TILE_PER_LINE    = 160,
    parameter int TILES_PER_ROW    = 5,
    parameter int FBUFF_ADDR_WIDTH = 12
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        frame_start_i,
    input  logic                        line_end_i,
    input  logic [1:0]                  buff_fill_done_i,
    output logic [1:0]                  buff_fill_req_o,
    output logic [1:0]                  buff_sel_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_row_addr_o,
    output logic                        underrun_o,
    output logic [15:0]                 underrun_cnt_o
);
    localparam int ROW_STRIDE = TILE_PER_LINE / TILES_PER_ROW;
    localparam int TILE_ROWS  = HEIGHT_PX / TILE_HEIGHT;
    localparam int TW         = TILE_ROWS > 1 ? $clog2(TILE_ROWS) : 1;
    localparam int LW         = TILE_HEIGHT > 1 ? $clog2(TILE_HEIGHT) : 1;
    localparam int AW         = FBUFF_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, PRIME, DISPLAY, DRAIN} state_t;

    state_t        state_r, state_n;
    logic [1:0]    req_r, req_n, sel_r, sel_n, req_kept;
    logic [AW-1:0] addr_r, addr_n;
    logic [TW-1:0] tile_r, tile_n;
    logic [LW-1:0] lit_r, lit_n;
    logic          ready_r, ready_n, under_r, under_n, done_hit, ready_eff, resync;
    logic [31:0]   row2;

    // only a done for the buffer currently requested counts
    assign done_hit  = |(buff_fill_done_i & req_r);
    assign req_kept  = done_hit ? 2'b00 : req_r;
    assign ready_eff = ready_r | done_hit;
    assign row2      = 32'(tile_r) + 32'd2;
    assign resync    = frame_start_i && (state_r == PRIME || state_r == DISPLAY);

    always_comb begin
        state_n = state_r;
        req_n   = req_kept;
        sel_n   = sel_r;
        addr_n  = addr_r;
        tile_n  = tile_r;
        lit_n   = lit_r;
        ready_n = ready_eff;
        under_n = 1'b0;
        case (state_r)
            IDLE: if (frame_start_i) begin
                req_n   = 2'b01;
                addr_n  = '0;
                state_n = PRIME;
            end
            PRIME: if (done_hit) begin
                sel_n   = 2'b01;
                req_n   = 2'b10;
                addr_n  = AW'(ROW_STRIDE);
                tile_n  = '0;
                lit_n   = '0;
                ready_n = 1'b0;
                state_n = DISPLAY;
            end
            DISPLAY: if (line_end_i) begin
                if (lit_r < LW'(TILE_HEIGHT - 1))
                    lit_n = lit_r + 1'b1;
                else if (tile_r == TW'(TILE_ROWS - 1)) begin
                    sel_n   = '0;
                    ready_n = 1'b0;
                    state_n = IDLE;
                end else if (ready_eff) begin
                    sel_n   = {sel_r[0], sel_r[1]};
                    tile_n  = tile_r + 1'b1;
                    lit_n   = '0;
                    ready_n = 1'b0;
                    if (row2 < 32'(TILE_ROWS)) begin
                        req_n  = sel_r;
                        addr_n = AW'(row2 * 32'(ROW_STRIDE));
                    end
                end else
                    under_n = 1'b1;
            end
            DRAIN: if (done_hit) begin
                req_n   = 2'b01;
                addr_n  = '0;
                state_n = PRIME;
            end
            default: ;
        endcase
        // a pending fill must finish before the new frame is primed
        if (resync) begin
            sel_n   = '0;
            ready_n = 1'b0;
            under_n = 1'b0;
            state_n = |req_kept ? DRAIN : PRIME;
            req_n   = |req_kept ? req_kept : 2'b01;
            addr_n  = |req_kept ? addr_r : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
            req_r   <= '0;
            sel_r   <= '0;
            addr_r  <= '0;
            tile_r  <= '0;
            lit_r   <= '0;
            ready_r <= 1'b0;
            under_r <= 1'b0;
        end else begin
            state_r <= state_n;
            req_r   <= req_n;
            sel_r   <= sel_n;
            addr_r  <= addr_n;
            tile_r  <= tile_n;
            lit_r   <= lit_n;
            ready_r <= ready_n;
            under_r <= under_n;
        end
    end

    assign buff_fill_req_o  = req_r;
    assign buff_sel_o       = sel_r;
    assign fbuff_row_addr_o = addr_r;
    assign underrun_o       = under_r;

`ifdef LBUFF_SCHED_UNDERRUN_CNT_EN
    logic [15:0] cnt_r;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            cnt_r <= '0;
        else if (under_n && cnt_r != 16'hFFFF)
            cnt_r <= cnt_r + 16'd1;
    end
    assign underrun_cnt_o = cnt_r;
`else
    assign underrun_cnt_o = '0;
`endif
endmodule

// File: tb/tb_line_buff_sched.sv
// tb_line_buff_sched: scoreboard bench for line_buff_sched; stimulus queues expected outputs,
// a negedge monitor pops one entry whenever the outputs change or underrun_o pulses.
module tb_line_buff_sched;
`ifdef LBUFF_SCHED_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0, rstn = 1'b0, frame_start = 1'b0, line_end = 1'b0;
    logic [1:0]  done = 2'b00, req, sel;
    logic [11:0] addr;
    logic        under;
    logic [15:0] cnt;

    line_buff_sched dut (
        .clk_i(clk), .rstn_i(rstn), .frame_start_i(frame_start), .line_end_i(line_end),
        .buff_fill_done_i(done), .buff_fill_req_o(req), .buff_sel_o(sel),
        .fbuff_row_addr_o(addr), .underrun_o(under), .underrun_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  req;
        logic [1:0]  sel;
        logic [11:0] addr;
        logic        und;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0, dut_swaps = 0;
    logic [15:0] cur, prev = '0, last_t = '0;

    // reference model state
    int          m_st = 0, m_tile = 0, m_lit = 0;
    logic [1:0]  m_req = '0, m_sel = '0;
    logic [11:0] m_addr = '0;
    bit          m_rdy = 0;
    logic [15:0] ucnt = '0;

    always @(negedge clk) begin
        cur = {req, sel, addr};
        if (rstn && (cur != prev || under)) begin
            if (sel != 2'b00 && prev[13:12] != 2'b00 && sel != prev[13:12]) dut_swaps++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: req=%b sel=%b addr=%0d und=%b with no expectation queued",
                         req, sel, addr, under);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({req, sel, addr, under, cnt} !== {e.req, e.sel, e.addr, e.und, e.cnt}) begin
                    errors++;
                    $display("FAIL %s: got req=%b sel=%b addr=%0d und=%b cnt=%0d, expected req=%b sel=%b addr=%0d und=%b cnt=%0d",
                             e.nm, req, sel, addr, under, cnt, e.req, e.sel, e.addr, e.und, e.cnt);
                end
            end
        end
        prev = cur;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, ex);
        end
    endtask

    task automatic post(input string nm, input bit und);
        logic [15:0] t;
        t = {m_req, m_sel, m_addr};
        if (t != last_t || und) q.push_back('{nm, m_req, m_sel, m_addr, und, CNT_EN ? ucnt : 16'd0});
        last_t = t;
    endtask

    task automatic step(input bit fs, input bit le, input logic [1:0] dn, input string nm);
        bit hit, und;
        hit = (dn & m_req) != 2'b00;
        und = 0;
        if (fs && (m_st == 1 || m_st == 2)) begin
            if (hit) m_req = 2'b00;
            m_sel = 2'b00;
            m_rdy = 0;
            if (m_req != 2'b00) m_st = 3;
            else begin m_req = 2'b01; m_addr = 0; m_st = 1; end
        end else case (m_st)
            0: if (fs) begin m_req = 2'b01; m_addr = 0; m_st = 1; end
            1: if (hit) begin
                m_sel = 2'b01; m_req = 2'b10; m_addr = 32; m_tile = 0; m_lit = 0; m_rdy = 0; m_st = 2;
            end
            2: begin
                if (hit) begin m_req = 2'b00; m_rdy = 1; end
                if (le) begin
                    if (m_lit < 3) m_lit++;
                    else if (m_tile == 119) begin m_sel = 2'b00; m_st = 0; end
                    else if (m_rdy) begin
                        if (m_tile + 2 < 120) begin m_req = m_sel; m_addr = 12'((m_tile + 2) * 32); end
                        m_sel = {m_sel[0], m_sel[1]};
                        m_tile++;
                        m_lit = 0;
                        m_rdy = 0;
                    end else begin und = 1; ucnt++; end
                end
            end
            3: if (hit) begin m_req = 2'b01; m_addr = 0; m_st = 1; end
            default: ;
        endcase
        post(nm, und);
        frame_start = fs; line_end = le; done = dn;
        @(posedge clk); #1;
        frame_start = 0; line_end = 0; done = 2'b00;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_req"}, 32'(req), 0);
        chk({nm, "_sel"}, 32'(sel), 0);
        chk({nm, "_addr"}, 32'(addr), 0);
        chk({nm, "_und"}, 32'(under), 0);
        chk({nm, "_cnt"}, 32'(cnt), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rstn = 1;
        repeat (3) step(0, 0, 2'b00, "idle");

        // frame 1: prime then a full steady frame
        step(1, 0, 2'b00, "prime_req");
        chk("prime_req_val", 32'(req), 1);
        chk("prime_addr", 32'(addr), 0);
        repeat (9) step(0, 0, 2'b00, "idle");
        step(0, 0, 2'b01, "prime_done");
        chk("prime_sel", 32'(sel), 1);
        chk("prime_next_addr", 32'(addr), 32);
        for (int ln = 0; ln < 480; ln++) begin
            step(0, 0, 2'b00, "idle");
            step(0, 0, m_req, "fill_done");
            step(0, 1, 2'b00, "line_end");
            if (ln == 23) chk("row_addr_from_tile5", 32'(addr), 224);
            if (ln == 471) chk("row_addr_last", 32'(addr), 3808);
            if (ln == 475) chk("no_req_row120", 32'(req), 0);
        end
        chk("frame_end_sel", 32'(sel), 0);
        chk("frame_swaps", 32'(dut_swaps), 119);

        // frame 2: underrun, coincident done, resync
        step(1, 0, 2'b00, "prime_req2");
        step(0, 0, 2'b00, "idle");
        step(0, 0, 2'b01, "prime_done2");
        repeat (3) step(0, 1, 2'b00, "line_end");
        step(0, 1, 2'b00, "underrun");
        chk("underrun_sel_hold", 32'(sel), 1);
        chk("underrun_req_hold", 32'(req), 2);
        chk("underrun_cnt", 32'(cnt), CNT_EN ? 1 : 0);
        step(0, 0, 2'b10, "late_done");
        step(0, 1, 2'b00, "swap_after_underrun");
        chk("swap_after_underrun_sel", 32'(sel), 2);
        chk("swap_after_underrun_addr", 32'(addr), 64);
        repeat (3) step(0, 1, 2'b00, "line_end");
        step(0, 1, 2'b01, "coincident_swap");
        chk("coincident_sel", 32'(sel), 1);
        chk("coincident_addr", 32'(addr), 96);
        chk("coincident_no_underrun", 32'(under), 0);
        step(0, 0, 2'b00, "idle");
        step(1, 0, 2'b00, "resync_drain");
        chk("resync_sel", 32'(sel), 0);
        chk("resync_req_held", 32'(req), 2);
        step(0, 0, 2'b01, "ignored_done");
        chk("ignored_done_req", 32'(req), 2);
        step(0, 0, 2'b10, "drain_done");
        chk("drain_reprime_req", 32'(req), 1);
        chk("drain_reprime_addr", 32'(addr), 0);
        step(0, 0, 2'b01, "prime_done3");
        step(0, 0, 2'b10, "fill_done");
        step(1, 0, 2'b00, "resync_immediate");
        chk("resync_immediate_req", 32'(req), 1);
        step(0, 0, 2'b01, "prime_done4");
        chk("before_reset_req", 32'(req), 2);

        // asynchronous reset while a fill is outstanding
        @(posedge clk);
        #3 rstn = 0;
        #1 chk_zero("async_reset");
        m_st = 0; m_req = '0; m_sel = '0; m_addr = '0; m_rdy = 0; ucnt = '0; last_t = '0;
        @(posedge clk);
        #3 rstn = 1;
        @(posedge clk);
        #1;
        repeat (10) step(0, 0, 2'b00, "idle_after_reset");
        chk_zero("post_reset");

        repeat (3) @(posedge clk);
        chk("scoreboard_drain", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
